issue_queue: RTL and testbench

Out-of-order issue queue (reservation station) that produces the operand/control bundle consumed by the execute stage. It holds dispatched instructions until both source operands are available, captures operand values from the execute-stage result broadcast (wakeup), and each cycle issues the oldest ready entry into registered outputs that feed execute one-for-one. It sits between dispatch/rename and execute.

---
 rtl/issue_queue_pkg.sv | 31 +++
 rtl/iq_age_select.sv | 28 ++
 rtl/issue_queue.sv | 198 +++++++++++++++++++
 tb/tb_issue_queue.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_queue_pkg.sv
// rtl/issue_queue_pkg.sv - shared widths, entry/issue structs and bubble constant for the issue queue
package issue_queue_pkg;

   localparam int IQ_TAG_W   = 6;
   localparam int IQ_ALU_W   = 6;
   localparam int IQ_SHAMT_W = 5;

   // Everything handed to execute except the destination tag, whose width is a top-level parameter.
   typedef struct packed {
      logic [31:0]            instr;
      logic [31:0]            pc;
      logic [31:0]            op_a;
      logic [31:0]            op_b;
      logic [31:0]            age;
      logic                   reg_write;
      logic                   mem_read;
      logic                   mem_write;
      logic [IQ_ALU_W-1:0]    alu_ctrl;
      logic [IQ_SHAMT_W-1:0]  shamt;
   } iq_issue_t;

   typedef struct packed {
      logic       valid;
      logic       rdy_a;
      logic       rdy_b;
      iq_issue_t  bundle;
   } iq_entry_t;

   localparam iq_issue_t IQ_NOP = '0;

endpackage

// File: rtl/iq_age_select.sv
// rtl/iq_age_select.sv - combinational oldest-ready arbiter over the issue queue entries
module iq_age_select #(
   parameter int DEPTH = 8,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0]    ready,
   input  logic [DEPTH*32-1:0] ages,
   output logic [IDX_W-1:0]    sel_idx,
   output logic                found
);

   logic [31:0] best_age;

   // Strict less-than while scanning upward, so equal ages resolve to the lowest index.
   always_comb begin
      sel_idx  = '0;
      found    = 1'b0;
      best_age = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ready[i] && (!found || (ages[i*32 +: 32] < best_age))) begin
            found    = 1'b1;
            best_age = ages[i*32 +: 32];
            sel_idx  = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - out-of-order issue queue: dispatch, result wakeup, oldest-ready select, registered issue
module issue_queue
   import issue_queue_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int TAG_W = IQ_TAG_W
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  Disp_valid_IN,
   output logic                  Disp_ready_OUT,
   input  logic [31:0]           Disp_Instr_IN,
   input  logic [31:0]           Disp_PC_IN,
   input  logic [TAG_W-1:0]      Disp_SrcA_Tag_IN,
   input  logic [TAG_W-1:0]      Disp_SrcB_Tag_IN,
   input  logic                  Disp_SrcA_Rdy_IN,
   input  logic                  Disp_SrcB_Rdy_IN,
   input  logic [31:0]           Disp_SrcA_Val_IN,
   input  logic [31:0]           Disp_SrcB_Val_IN,
   input  logic [TAG_W-1:0]      Disp_WriteRegister_IN,
   input  logic                  Disp_RegWrite_IN,
   input  logic                  Disp_MemRead_IN,
   input  logic                  Disp_MemWrite_IN,
   input  logic [IQ_ALU_W-1:0]   Disp_ALU_Control_IN,
   input  logic [IQ_SHAMT_W-1:0] Disp_ShiftAmount_IN,
   input  logic [31:0]           Disp_InstrAge_IN,
   input  logic                  WB_RegWrite_IN,
   input  logic [TAG_W-1:0]      WB_WriteRegister_IN,
   input  logic [31:0]           WB_Result_IN,
   input  logic                  IF_stall_request,
   input  logic                  Flush_IN,
   output logic                  Issue_valid_OUT,
   output logic [31:0]           Instr1_OUT,
   output logic [31:0]           Instr1_PC_OUT,
   output logic [31:0]           OperandA1_OUT,
   output logic [31:0]           OperandB1_OUT,
   output logic [31:0]           InstrAge_OUT,
   output logic [TAG_W-1:0]      WriteRegister1_OUT,
   output logic                  RegWrite1_OUT,
   output logic                  MemRead1_OUT,
   output logic                  MemWrite1_OUT,
   output logic [IQ_ALU_W-1:0]   ALU_Control1_OUT,
   output logic [IQ_SHAMT_W-1:0] ShiftAmount1_OUT
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   iq_entry_t        entry_q [DEPTH];
   logic [TAG_W-1:0] tag_a_q [DEPTH];
   logic [TAG_W-1:0] tag_b_q [DEPTH];
   logic [TAG_W-1:0] wreg_q  [DEPTH];
   logic [CNT_W-1:0] count_q;

   iq_issue_t        out_q;
   logic [TAG_W-1:0] out_wreg_q;
   logic             out_valid_q;

   logic [IDX_W-1:0]    free_idx;
   logic [IDX_W-1:0]    sel_idx;
   logic                sel_found;
   logic [DEPTH-1:0]    ready_vec;
   logic [DEPTH*32-1:0] age_flat;
   logic                do_disp;
   logic                do_issue;
   logic                snoop_a;
   logic                snoop_b;
   iq_entry_t           new_entry;

   assign Disp_ready_OUT = (count_q != CNT_W'(DEPTH));
   assign do_disp        = Disp_valid_IN && Disp_ready_OUT;
   assign do_issue       = !IF_stall_request && sel_found;

   always_comb begin
      free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!entry_q[i].valid) free_idx = IDX_W'(i);
      end
   end

   always_comb begin
      ready_vec = '0;
      age_flat  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ready_vec[i]        = entry_q[i].valid && entry_q[i].rdy_a && entry_q[i].rdy_b;
         age_flat[i*32 +: 32] = entry_q[i].bundle.age;
      end
   end

   iq_age_select #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_age_select (
      .ready   (ready_vec),
      .ages    (age_flat),
      .sel_idx (sel_idx),
      .found   (sel_found)
   );

   // A dispatched source that matches this cycle's broadcast is captured now, or it would miss the value forever.
   assign snoop_a = WB_RegWrite_IN && !Disp_SrcA_Rdy_IN && (WB_WriteRegister_IN == Disp_SrcA_Tag_IN);
   assign snoop_b = WB_RegWrite_IN && !Disp_SrcB_Rdy_IN && (WB_WriteRegister_IN == Disp_SrcB_Tag_IN);

   always_comb begin
      new_entry                  = '0;
      new_entry.valid            = 1'b1;
      new_entry.rdy_a            = Disp_SrcA_Rdy_IN || snoop_a;
      new_entry.rdy_b            = Disp_SrcB_Rdy_IN || snoop_b;
      new_entry.bundle.instr     = Disp_Instr_IN;
      new_entry.bundle.pc        = Disp_PC_IN;
      new_entry.bundle.op_a      = Disp_SrcA_Rdy_IN ? Disp_SrcA_Val_IN : (snoop_a ? WB_Result_IN : '0);
      new_entry.bundle.op_b      = Disp_SrcB_Rdy_IN ? Disp_SrcB_Val_IN : (snoop_b ? WB_Result_IN : '0);
      new_entry.bundle.age       = Disp_InstrAge_IN;
      new_entry.bundle.reg_write = Disp_RegWrite_IN;
      new_entry.bundle.mem_read  = Disp_MemRead_IN;
      new_entry.bundle.mem_write = Disp_MemWrite_IN;
      new_entry.bundle.alu_ctrl  = Disp_ALU_Control_IN;
      new_entry.bundle.shamt     = Disp_ShiftAmount_IN;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry_q[i] <= '0;
            tag_a_q[i] <= '0;
            tag_b_q[i] <= '0;
            wreg_q[i]  <= '0;
         end
         count_q     <= '0;
         out_q       <= IQ_NOP;
         out_wreg_q  <= '0;
         out_valid_q <= 1'b0;
      end else if (Flush_IN) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry_q[i].valid <= 1'b0;
         end
         count_q     <= '0;
         out_q       <= IQ_NOP;
         out_wreg_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (entry_q[i].valid && WB_RegWrite_IN) begin
               if (!entry_q[i].rdy_a && (tag_a_q[i] == WB_WriteRegister_IN)) begin
                  entry_q[i].rdy_a       <= 1'b1;
                  entry_q[i].bundle.op_a <= WB_Result_IN;
               end
               if (!entry_q[i].rdy_b && (tag_b_q[i] == WB_WriteRegister_IN)) begin
                  entry_q[i].rdy_b       <= 1'b1;
                  entry_q[i].bundle.op_b <= WB_Result_IN;
               end
            end
         end

         if (do_issue) entry_q[sel_idx].valid <= 1'b0;

         // free_idx names an invalid slot, so it can never collide with the issuing entry.
         if (do_disp) begin
            entry_q[free_idx] <= new_entry;
            tag_a_q[free_idx] <= Disp_SrcA_Tag_IN;
            tag_b_q[free_idx] <= Disp_SrcB_Tag_IN;
            wreg_q[free_idx]  <= Disp_WriteRegister_IN;
         end

         case ({do_disp, do_issue})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase

         if (!IF_stall_request) begin
            if (sel_found) begin
               out_q       <= entry_q[sel_idx].bundle;
               out_wreg_q  <= wreg_q[sel_idx];
               out_valid_q <= 1'b1;
            end else begin
               out_q       <= IQ_NOP;
               out_wreg_q  <= '0;
               out_valid_q <= 1'b0;
            end
         end
      end
   end

   assign Issue_valid_OUT    = out_valid_q;
   assign Instr1_OUT         = out_q.instr;
   assign Instr1_PC_OUT      = out_q.pc;
   assign OperandA1_OUT      = out_q.op_a;
   assign OperandB1_OUT      = out_q.op_b;
   assign InstrAge_OUT       = out_q.age;
   assign WriteRegister1_OUT = out_wreg_q;
   assign RegWrite1_OUT      = out_q.reg_write;
   assign MemRead1_OUT       = out_q.mem_read;
   assign MemWrite1_OUT      = out_q.mem_write;
   assign ALU_Control1_OUT   = out_q.alu_ctrl;
   assign ShiftAmount1_OUT   = out_q.shamt;

endmodule

// File: tb/tb_issue_queue.sv
// tb/tb_issue_queue.sv - scoreboard bench for issue_queue
module tb_issue_queue;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        Disp_valid_IN;
   logic        Disp_ready_OUT;
   logic [31:0] Disp_Instr_IN, Disp_PC_IN;
   logic [5:0]  Disp_SrcA_Tag_IN, Disp_SrcB_Tag_IN;
   logic        Disp_SrcA_Rdy_IN, Disp_SrcB_Rdy_IN;
   logic [31:0] Disp_SrcA_Val_IN, Disp_SrcB_Val_IN;
   logic [5:0]  Disp_WriteRegister_IN;
   logic        Disp_RegWrite_IN, Disp_MemRead_IN, Disp_MemWrite_IN;
   logic [5:0]  Disp_ALU_Control_IN;
   logic [4:0]  Disp_ShiftAmount_IN;
   logic [31:0] Disp_InstrAge_IN;
   logic        WB_RegWrite_IN;
   logic [5:0]  WB_WriteRegister_IN;
   logic [31:0] WB_Result_IN;
   logic        IF_stall_request, Flush_IN;
   logic        Issue_valid_OUT;
   logic [31:0] Instr1_OUT, Instr1_PC_OUT, OperandA1_OUT, OperandB1_OUT, InstrAge_OUT;
   logic [5:0]  WriteRegister1_OUT;
   logic        RegWrite1_OUT, MemRead1_OUT, MemWrite1_OUT;
   logic [5:0]  ALU_Control1_OUT;
   logic [4:0]  ShiftAmount1_OUT;

   issue_queue #(.DEPTH(8), .TAG_W(6)) dut (
      .CLK(CLK), .RESET(RESET),
      .Disp_valid_IN(Disp_valid_IN), .Disp_ready_OUT(Disp_ready_OUT),
      .Disp_Instr_IN(Disp_Instr_IN), .Disp_PC_IN(Disp_PC_IN),
      .Disp_SrcA_Tag_IN(Disp_SrcA_Tag_IN), .Disp_SrcB_Tag_IN(Disp_SrcB_Tag_IN),
      .Disp_SrcA_Rdy_IN(Disp_SrcA_Rdy_IN), .Disp_SrcB_Rdy_IN(Disp_SrcB_Rdy_IN),
      .Disp_SrcA_Val_IN(Disp_SrcA_Val_IN), .Disp_SrcB_Val_IN(Disp_SrcB_Val_IN),
      .Disp_WriteRegister_IN(Disp_WriteRegister_IN),
      .Disp_RegWrite_IN(Disp_RegWrite_IN), .Disp_MemRead_IN(Disp_MemRead_IN),
      .Disp_MemWrite_IN(Disp_MemWrite_IN), .Disp_ALU_Control_IN(Disp_ALU_Control_IN),
      .Disp_ShiftAmount_IN(Disp_ShiftAmount_IN), .Disp_InstrAge_IN(Disp_InstrAge_IN),
      .WB_RegWrite_IN(WB_RegWrite_IN), .WB_WriteRegister_IN(WB_WriteRegister_IN),
      .WB_Result_IN(WB_Result_IN), .IF_stall_request(IF_stall_request), .Flush_IN(Flush_IN),
      .Issue_valid_OUT(Issue_valid_OUT), .Instr1_OUT(Instr1_OUT), .Instr1_PC_OUT(Instr1_PC_OUT),
      .OperandA1_OUT(OperandA1_OUT), .OperandB1_OUT(OperandB1_OUT), .InstrAge_OUT(InstrAge_OUT),
      .WriteRegister1_OUT(WriteRegister1_OUT), .RegWrite1_OUT(RegWrite1_OUT),
      .MemRead1_OUT(MemRead1_OUT), .MemWrite1_OUT(MemWrite1_OUT),
      .ALU_Control1_OUT(ALU_Control1_OUT), .ShiftAmount1_OUT(ShiftAmount1_OUT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] op_a;
      logic [31:0] op_b;
      logic [31:0] age;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic push_exp(input logic [31:0] age, input logic [31:0] instr,
                           input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      e.instr = instr; e.op_a = a; e.op_b = b; e.age = age;
      exp_q.push_back(e);
   endtask

   task automatic idle();
      Disp_valid_IN = 1'b0; WB_RegWrite_IN = 1'b0; Flush_IN = 1'b0;
   endtask

   task automatic drive_disp(input logic [31:0] age, input logic [31:0] instr,
                             input logic [5:0] ta, input logic ra, input logic [31:0] va,
                             input logic [5:0] tb, input logic rb, input logic [31:0] vb);
      Disp_valid_IN = 1'b1;
      Disp_Instr_IN = instr; Disp_PC_IN = instr + 32'h1000;
      Disp_SrcA_Tag_IN = ta; Disp_SrcA_Rdy_IN = ra; Disp_SrcA_Val_IN = va;
      Disp_SrcB_Tag_IN = tb; Disp_SrcB_Rdy_IN = rb; Disp_SrcB_Val_IN = vb;
      Disp_WriteRegister_IN = instr[5:0]; Disp_RegWrite_IN = 1'b1;
      Disp_MemRead_IN = age[0]; Disp_MemWrite_IN = age[1];
      Disp_ALU_Control_IN = 6'b000000; Disp_ShiftAmount_IN = instr[4:0];
      Disp_InstrAge_IN = age;
   endtask

   task automatic broadcast(input logic [5:0] tag, input logic [31:0] val);
      WB_RegWrite_IN = 1'b1; WB_WriteRegister_IN = tag; WB_Result_IN = val;
   endtask

   // Advances one edge and scores any fresh issue; held outputs under stall or a flush edge are not new issues.
   task automatic step();
      logic stall_prev, flush_prev;
      exp_t e;
      stall_prev = IF_stall_request;
      flush_prev = Flush_IN;
      @(posedge CLK); #1;
      if (Issue_valid_OUT && !stall_prev && !flush_prev && RESET) begin
         if (exp_q.size() == 0) begin
            check("unexpected_issue", {32'd0, InstrAge_OUT}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("issue_age",   {32'd0, InstrAge_OUT},  {32'd0, e.age});
            check("issue_instr", {32'd0, Instr1_OUT},    {32'd0, e.instr});
            check("issue_pc",    {32'd0, Instr1_PC_OUT}, {32'd0, e.instr + 32'h1000});
            check("issue_op_a",  {32'd0, OperandA1_OUT}, {32'd0, e.op_a});
            check("issue_op_b",  {32'd0, OperandB1_OUT}, {32'd0, e.op_b});
            check("issue_wreg",  {58'd0, WriteRegister1_OUT}, {58'd0, e.instr[5:0]});
            check("issue_flags", {61'd0, RegWrite1_OUT, MemRead1_OUT, MemWrite1_OUT},
                  {61'd0, 1'b1, e.age[0], e.age[1]});
         end
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         step();
         n++;
      end
      check("drain_done", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_bubble(input string tag);
      check({tag, "_valid"}, {63'd0, Issue_valid_OUT}, 64'd0);
      check({tag, "_outs"}, {Instr1_OUT, OperandA1_OUT | OperandB1_OUT | InstrAge_OUT | Instr1_PC_OUT}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      RESET = 1'b0; IF_stall_request = 1'b0;
      drive_disp(0, 0, 0, 0, 0, 0, 0, 0);
      idle();
      WB_WriteRegister_IN = '0; WB_Result_IN = '0;
      repeat (3) @(posedge CLK);
      #1;
      check_bubble("reset");
      check("reset_disp_ready", {63'd0, Disp_ready_OUT}, 64'd1);
      @(negedge CLK); RESET = 1'b1;
      @(posedge CLK); #1;

      // Basic add: dispatch at one edge, issue at the next.
      drive_disp(1, 32'h0000_0020, 1, 1, 5, 2, 1, 7);
      push_exp(1, 32'h0000_0020, 5, 7);
      step(); idle();
      step();
      check("basic_issued", 64'(exp_q.size()), 64'd0);
      step();
      check_bubble("after_basic");

      // Older entry waiting on tag 12 is passed by a younger ready one, then wakes.
      drive_disp(10, 32'h0000_0A01, 1, 1, 32'h11, 12, 0, 32'hDEAD);
      step();
      drive_disp(20, 32'h0000_1402, 1, 1, 32'h2, 2, 1, 32'h3);
      push_exp(20, 32'h0000_1402, 32'h2, 32'h3);
      step(); idle();
      broadcast(12, 32'h99);
      push_exp(10, 32'h0000_0A01, 32'h11, 32'h99);
      step(); idle();
      drain(4);

      // Dispatch snoops a same-cycle broadcast.
      drive_disp(30, 32'h0000_1E03, 3, 0, 32'hBEEF, 4, 1, 32'h8);
      broadcast(3, 32'h44);
      push_exp(30, 32'h0000_1E03, 32'h44, 32'h8);
      step(); idle();
      drain(3);
      step();

      // Stall holds the issued outputs for three cycles.
      drive_disp(60, 32'h0000_3C04, 1, 1, 32'h60, 2, 1, 32'h61);
      push_exp(60, 32'h0000_3C04, 32'h60, 32'h61);
      step();
      drive_disp(61, 32'h0000_3D05, 1, 1, 32'h70, 2, 1, 32'h71);
      push_exp(61, 32'h0000_3D05, 32'h70, 32'h71);
      step(); idle();
      IF_stall_request = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_hold_valid", {63'd0, Issue_valid_OUT}, 64'd1);
         check("stall_hold_instr", {32'd0, Instr1_OUT}, {32'd0, 32'h0000_3C04});
      end
      IF_stall_request = 1'b0;
      drain(3);
      step();

      // Flush: three waiting entries plus one ready entry, with a dispatch in the flush cycle.
      for (int i = 0; i < 3; i++) begin
         drive_disp(70 + i, 32'h0000_4600 + i, 50, 0, 0, 2, 1, 1);
         step();
      end
      drive_disp(69, 32'h0000_4500, 1, 1, 1, 2, 1, 1);
      step();
      drive_disp(74, 32'h0000_4A00, 1, 1, 1, 2, 1, 1);
      Flush_IN = 1'b1;
      step(); idle();
      check_bubble("flush");
      broadcast(50, 32'h50);
      step(); idle();
      for (int i = 0; i < 4; i++) step();
      check_bubble("post_flush");

      // Exactly eight fit after the flush; the ninth is dropped.
      for (int i = 0; i < 8; i++) begin
         drive_disp(100 + i, 32'h0000_6400 + i, 1, 1, 32'h100 + i, 40, 0, 0);
         step();
         check("fill_disp_ready", {63'd0, Disp_ready_OUT}, (i < 7) ? 64'd1 : 64'd0);
      end
      drive_disp(1, 32'h0000_0999, 1, 1, 1, 2, 1, 1);
      step(); idle();
      check_bubble("full_not_ready");
      broadcast(40, 32'h40);
      for (int i = 0; i < 8; i++) push_exp(100 + i, 32'h0000_6400 + i, 32'h100 + i, 32'h40);
      step(); idle();
      check("full_issue_cycle_ready", {63'd0, Disp_ready_OUT}, 64'd0);
      step();
      check("after_first_drain_ready", {63'd0, Disp_ready_OUT}, 64'd1);
      drain(10);
      step();
      check_bubble("after_fill_drain");

      // Asynchronous reset in the middle of issue.
      drive_disp(200, 32'h0000_C800, 1, 1, 32'h200, 2, 1, 32'h201);
      push_exp(200, 32'h0000_C800, 32'h200, 32'h201);
      step();
      drive_disp(201, 32'h0000_C900, 60, 0, 0, 2, 1, 1);
      step(); idle();
      check("pre_reset_valid", {63'd0, Issue_valid_OUT}, 64'd1);
      #2 RESET = 1'b0;
      #1;
      check_bubble("async_reset");
      check("async_reset_ready", {63'd0, Disp_ready_OUT}, 64'd1);
      @(negedge CLK); RESET = 1'b1;
      broadcast(60, 32'h60);
      step(); idle();
      for (int i = 0; i < 3; i++) step();
      check_bubble("post_reset");

      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
